// File: rtl/hcordic_fp_pkg.sv
// Shared constants and state encoding for the HCORDIC float pipeline stages.
package hcordic_fp_pkg;

  localparam int unsigned SIGN_BIT = 32;
  localparam int unsigned EXP_HI   = 31;
  localparam int unsigned EXP_LO   = 24;
  localparam int unsigned MANT_HI  = 23;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned PROD_W   = 50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/shift_add_mult_core.sv
// Radix-2 shift-add multiplier datapath: one partial product per cycle for W cycles.
module shift_add_mult_core #(
  parameter int unsigned W = 24
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           last,
  output logic [2*W-1:0] result
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mc;
  logic [W-1:0]     mp;
  logic [CNT_W-1:0] count;
  logic             running;

  // result is the accumulator after this cycle's add, so the caller can
  // capture the full product on the same edge as the final iteration
  assign result = acc + (mp[0] ? mc : '0);
  assign last   = running && (count == CNT_W'(W - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mc      <= {{W{1'b0}}, mcand};
      mp      <= mplier;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc   <= result;
      mc    <= mc << 1;
      mp    <= mp >> 1;
      count <= count + CNT_W'(1);
      if (last) running <= 1'b0;
    end
  end

endmodule

// File: rtl/multiply_descale_iter.sv
// Iterative mantissa multiplier producing sign, exponent sum and product for
// the descale normalise-product stage; idle ops bypass the multiplier.
module multiply_descale_iter #(
  parameter int unsigned MANT_W = hcordic_fp_pkg::MANT_W,
  parameter int unsigned EXP_W  = hcordic_fp_pkg::EXP_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    idle_in,
  input  logic [MANT_W+EXP_W:0]   a_in,
  input  logic [MANT_W+EXP_W:0]   b_in,
  input  logic [7:0]              InsTag_in,
  input  logic                    ScaleValid_in,
  input  logic [31:0]             z_in,
  output logic                    out_valid,
  output logic                    idle_Multiply,
  output logic [MANT_W+EXP_W:0]   zout_Multiply,
  output logic [2*MANT_W+1:0]     productout_Multiply,
  output logic [7:0]              InsTagMultiply,
  output logic                    ScaleValidMultiply,
  output logic [31:0]             z_Multiply
);

  import hcordic_fp_pkg::*;

  localparam int unsigned SGN = MANT_W + EXP_W;
  localparam int unsigned EHI = MANT_W + EXP_W - 1;
  localparam int unsigned ELO = MANT_W;
  localparam int unsigned MHI = MANT_W - 1;

  mult_state_e state, state_nxt;

  logic                  accept;
  logic                  start;
  logic                  core_last;
  logic [2*MANT_W-1:0]   core_result;
  logic                  res_sign_q;
  logic [EXP_W-1:0]      res_exp_q;
  logic [7:0]            tag_q;
  logic                  sv_q;
  logic [31:0]           z_q;

  assign accept = in_valid && in_ready;
  assign start  = accept && !idle_in;

  shift_add_mult_core #(.W(MANT_W)) u_core (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .mcand  (b_in[MHI:0]),
    .mplier (a_in[MHI:0]),
    .last   (core_last),
    .result (core_result)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = idle_in ? DONE : BUSY;
      BUSY:    if (core_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Sign and exponent are resolved at accept; only the mantissas need the core
  always_ff @(posedge clock) begin
    if (reset) begin
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      tag_q      <= '0;
      sv_q       <= 1'b0;
      z_q        <= '0;
    end else if (accept) begin
      res_sign_q <= a_in[SGN] ^ b_in[SGN];
      res_exp_q  <= a_in[EHI:ELO] + b_in[EHI:ELO] + EXP_W'(1);
      tag_q      <= InsTag_in;
      sv_q       <= ScaleValid_in;
      z_q        <= z_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_Multiply       <= 1'b0;
      zout_Multiply       <= '0;
      productout_Multiply <= '0;
      InsTagMultiply      <= '0;
      ScaleValidMultiply  <= 1'b0;
      z_Multiply          <= '0;
    end else if (accept && idle_in) begin
      idle_Multiply       <= 1'b1;
      zout_Multiply       <= a_in;
      productout_Multiply <= '0;
      InsTagMultiply      <= InsTag_in;
      ScaleValidMultiply  <= ScaleValid_in;
      z_Multiply          <= z_in;
    end else if (state == BUSY && core_last) begin
      idle_Multiply       <= 1'b0;
      zout_Multiply       <= {res_sign_q, res_exp_q, {MANT_W{1'b0}}};
      productout_Multiply <= {core_result, 2'b00};
      InsTagMultiply      <= tag_q;
      ScaleValidMultiply  <= sv_q;
      z_Multiply          <= z_q;
    end
  end

endmodule

// File: tb/tb_multiply_descale_iter.sv
// Scoreboard bench for multiply_descale_iter using directed operand vectors.
module tb_multiply_descale_iter;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        idle_in;
  logic [32:0] a_in;
  logic [32:0] b_in;
  logic [7:0]  InsTag_in;
  logic        ScaleValid_in;
  logic [31:0] z_in;
  logic        out_valid;
  logic        idle_Multiply;
  logic [32:0] zout_Multiply;
  logic [49:0] productout_Multiply;
  logic [7:0]  InsTagMultiply;
  logic        ScaleValidMultiply;
  logic [31:0] z_Multiply;

  multiply_descale_iter #(.MANT_W(24), .EXP_W(8)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .idle_in             (idle_in),
    .a_in                (a_in),
    .b_in                (b_in),
    .InsTag_in           (InsTag_in),
    .ScaleValid_in       (ScaleValid_in),
    .z_in                (z_in),
    .out_valid           (out_valid),
    .idle_Multiply       (idle_Multiply),
    .zout_Multiply       (zout_Multiply),
    .productout_Multiply (productout_Multiply),
    .InsTagMultiply      (InsTagMultiply),
    .ScaleValidMultiply  (ScaleValidMultiply),
    .z_Multiply          (z_Multiply)
  );

  typedef struct {
    logic [32:0] zout;
    logic [49:0] prod;
    logic        idl;
    logic [7:0]  tag;
    logic        sv;
    logic [31:0] z;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 expected=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("zout",       64'(zout_Multiply),       64'(e.zout));
        check("productout", 64'(productout_Multiply), 64'(e.prod));
        check("idle",       64'(idle_Multiply),       64'(e.idl));
        check("tag",        64'(InsTagMultiply),      64'(e.tag));
        check("scalevalid", 64'(ScaleValidMultiply),  64'(e.sv));
        check("z",          64'(z_Multiply),          64'(e.z));
        check("latency",    64'(cyc),                 64'(e.cyc));
      end
    end
  end

  // Presents an op and holds it until accepted; accept_cyc is the cycle count after the accepting edge.
  task automatic issue(input logic [32:0] a, input logic [32:0] b, input logic idl,
                       input logic [7:0] tag, input logic sv, input logic [31:0] z,
                       input logic [32:0] ez, input logic [49:0] ep, input bit push,
                       output int accept_cyc);
    int n;
    exp_t e;
    @(negedge clock);
    a_in = a; b_in = b; idle_in = idl; InsTag_in = tag; ScaleValid_in = sv; z_in = z;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    accept_cyc = cyc + 1;
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 expected=1");
    end else if (push) begin
      e.zout = ez; e.prod = ep; e.idl = idl; e.tag = tag; e.sv = sv; e.z = z;
      e.cyc  = accept_cyc + (idl ? 0 : 24);
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", q.size());
    end
    @(negedge clock);
  endtask

  task automatic check_zero_outputs(input string tagname);
    check({tagname, "_in_ready"},  64'(in_ready),  64'd1);
    check({tagname, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tagname, "_outputs"},
          64'({idle_Multiply, zout_Multiply, InsTagMultiply, ScaleValidMultiply, z_Multiply} != '0), 64'd0);
    check({tagname, "_product"},   64'(productout_Multiply), 64'd0);
  endtask

  initial begin
    int acc1, acc2, dummy, bp_bad;
    reset = 1'b1; in_valid = 1'b0; idle_in = 1'b0; a_in = '0; b_in = '0;
    InsTag_in = '0; ScaleValid_in = 1'b0; z_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_zero_outputs("reset");

    // 1.0 * 1.0
    issue(33'h0_0080_0000, 33'h0_0080_0000, 1'b0, 8'h11, 1'b1, 32'h0000_1111,
          33'h0_0100_0000, 50'h1_0000_0000_0000, 1'b1, dummy);
    drain();
    // 1.5 * -1.5, exponents 3 and -2
    issue(33'h0_03C0_0000, 33'h1_FEC0_0000, 1'b0, 8'h22, 1'b0, 32'hDEAD_BEEF,
          33'h1_0200_0000, 50'h2_4000_0000_0000, 1'b1, dummy);
    drain();
    // maximal mantissas, exponent wraps
    issue(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 1'b0, 8'h33, 1'b1, 32'h1234_5678,
          33'h0_FF00_0000, 50'h3_FFFF_F800_0004, 1'b1, dummy);
    drain();
    // idle bypass
    issue(33'h1_2345_6789, 33'h0_1357_9BDF, 1'b1, 8'hA5, 1'b1, 32'hCAFE_F00D,
          33'h1_2345_6789, 50'h0, 1'b1, dummy);
    drain();
    // zero mantissa
    issue(33'h1_0500_0000, 33'h0_02AB_CDEF, 1'b0, 8'h44, 1'b0, 32'h0000_0044,
          33'h1_0800_0000, 50'h0, 1'b1, dummy);
    drain();

    // back-pressure: operands change while busy and must be ignored
    issue(33'h0_01A0_0000, 33'h0_FF90_0000, 1'b0, 8'h55, 1'b1, 32'h5555_AAAA,
          33'h0_0100_0000, 50'h1_6800_0000_0000, 1'b1, acc1);
    bp_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      a_in = 33'h0_7FFF_FFFF - 33'(i); b_in = 33'h1_3F12_3456 + 33'(i);
      InsTag_in = 8'(8'hE0 + i); ScaleValid_in = i[0]; z_in = 32'(i);
      in_valid = 1'b1;
      if (in_ready !== 1'b0) bp_bad++;
    end
    check("busy_in_ready_low_cycles", 64'(bp_bad), 64'd0);
    issue(33'h0_0080_0000, 33'h1_1080_0001, 1'b0, 8'h66, 1'b0, 32'h6666_6666,
          33'h1_1100_0000, 50'h1_0000_0200_0000, 1'b1, acc2);
    check("next_accept_cycle", 64'(acc2), 64'(acc1 + 26));
    drain();

    // reset during BUSY abandons the op
    issue(33'h0_0080_0000, 33'h0_0080_0000, 1'b0, 8'h77, 1'b1, 32'h7777_7777,
          33'h0, 50'h0, 1'b0, dummy);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_zero_outputs("midreset");
    repeat (30) @(negedge clock);
    issue(33'h0_0080_0000, 33'h0_0080_0000, 1'b0, 8'h88, 1'b1, 32'h8888_0001,
          33'h0_0100_0000, 50'h1_0000_0000_0000, 1'b1, dummy);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiply_descale_iter.md
Name: multiply_descale_iter

Overview:
Iterative mantissa multiplier feeding the descale normalise-product stage of the HCORDIC float pipeline. Accepts two unpacked operands plus sideband (tag, scale-valid, z), and computes the sign, the unnormalised exponent sum and the 50-bit product. Outputs are in exactly the format the normalise-product stage consumes. Radix-2 shift-add over MANT_W cycles, which trades latency for area versus a combinational 24x24 multiplier.

Parameters:
MANT_W, 24, mantissa width incl. hidden bit; sets iteration count; product width = 2*MANT_W+2
EXP_W, 8, signed unbiased exponent width

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand offer
in_ready  output  1  high only in IDLE state
idle_in  input  1  1 = idle (bypass) operation
a_in  input  33  [32] sign, [31:24] signed exponent, [23:0] mantissa (bit 23 = hidden 1)
b_in  input  33  same format as a_in
InsTag_in  input  8  instruction tag, carried through
ScaleValid_in  input  1  carried through
z_in  input  32  carried through
out_valid  output  1  one-cycle result strobe
idle_Multiply  output  1  registered idle_in of the completed op
zout_Multiply  output  33  [32] sign, [31:24] exponent, [23:0] = 0 (bypass: a_in)
productout_Multiply  output  50  {ma*mb, 2'b00}
InsTagMultiply  output  8  registered tag
ScaleValidMultiply  output  1  registered
z_Multiply  output  32  registered

Behaviour:
- Reset (sync, high): state=IDLE; in_ready=1 the cycle after reset; out_valid=0; every other output =0; the iteration counter and accumulator are cleared. Reset mid-BUSY abandons the op with no out_valid.
- States: IDLE, BUSY, DONE.
- IDLE: an accept occurs when in_valid=1 in IDLE. On accept, latch a_in, b_in and the sideband.
  - idle_in=1: go to DONE directly. zout=a_in, productout=0, idle_Multiply=1. Latency 1 cycle.
  - idle_in=0: load multiplicand = mb. Load the multiplier shift register = ma. Clear the 48-bit accumulator and set count=0. Go to BUSY.
- BUSY: each cycle, if the multiplier LSB=1, add (mb << count) to the accumulator. Shift the multiplier right and increment count. After count reaches MANT_W-1 (24 iterations), go to DONE.
- DONE: register outputs and pulse out_valid=1 for exactly one cycle, then return to IDLE.
  - Non-idle op outputs:
    - sign = a[32]^b[32]
    - exponent = a_exp + b_exp + 1, computed modulo 2^EXP_W with no saturation or overflow flag
    - zout[23:0] = 0
    - productout = {acc[47:0], 2'b00}
- Latency from accept to out_valid: MANT_W+1 = 25 cycles for non-idle ops; 1 cycle for idle ops. Throughput is one op per 26 cycles.
- in_ready is combinational from state (1 only in IDLE). in_valid outside IDLE is ignored and operands are not sampled.
- Outputs hold their last values between out_valid pulses.
- Zero mantissa operand: processed normally and gives product 0. No special-casing.
- Sideband appears on the outputs unchanged, aligned with out_valid.

Decomposition:
- Shared package hcordic_fp_pkg holds:
  - field constants SIGN_BIT=32, EXP_HI=31, EXP_LO=24, MANT_HI=23
  - MANT_W, EXP_W, PROD_W=50
  - state encoding for IDLE/BUSY/DONE
- One natural sub-module: shift_add_mult_core (accumulator, multiplier shift register, counter; start/done interface).

Test Plan:
- 1.0*1.0: a=b={0,8'h00,24'h800000} -> after 25 cycles out_valid=1, zout={0,8'h01,24'h0}, productout=50'h1_0000_0000_0000.
- 1.5*(-1.5), exponents 3 and -2: a={0,8'h03,24'hC00000}, b={1,8'hFE,24'hC00000} -> zout={1,8'h02,24'h0}, productout=50'h2_4000_0000_0000.
- Max mantissas, exponents 8'h7F+8'h7F: ma=mb=24'hFFFFFF -> productout=50'h3_FFFF_F800_0004, exponent wraps to 8'hFF.
- Idle op: idle_in=1, a_in=33'h1_2345_6789, tag 8'hA5 -> out_valid after 1 cycle, zout=a_in, productout=0, idle_Multiply=1, InsTagMultiply=8'hA5.
- Back-pressure: hold in_valid=1 with changing operands during BUSY -> in_ready=0 throughout, the result reflects only the first accepted operands, and the next accept occurs the cycle after out_valid.
- Reset asserted at BUSY cycle 10 -> no out_valid, all outputs 0. A new op issued after reset completes correctly in 25 cycles.
